// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for the shared registered ALU.
// Issues one operation at a time and returns its result into a one-deep slot owned by the issuer.
module alu_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,

    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_arg0,
    input  logic [WIDTH-1:0] i_req0_arg1,
    input  logic [1:0]       i_req0_oper,

    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_arg0,
    input  logic [WIDTH-1:0] i_req1_arg1,
    input  logic [1:0]       i_req1_oper,

    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [WIDTH-1:0] o_rsp0_result,
    output logic [3:0]       o_rsp0_flag,

    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_rsp1_result,
    output logic [3:0]       o_rsp1_flag,

    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [1:0]       o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [3:0]       i_alu_flag,

    output logic             o_busy,
    output logic [7:0]       o_err_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t           state_q, state_d;
    logic             cur_id_q, cur_id_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] arg0_q, arg0_d, arg1_q, arg1_d;
    logic [1:0]       oper_q, oper_d;
    logic             v0_q, v0_d, v1_q, v1_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [3:0]       flg0_q, flg0_d, flg1_q, flg1_d;
    logic [7:0]       err_q, err_d;

    logic idle, elig0, elig1, gnt1, rdy0, rdy1;

    // Eligibility uses the registered slot state, so a slot drained this cycle only counts next cycle.
    always_comb begin
        idle  = (state_q == IDLE);
        elig0 = i_req0_valid & ~v0_q;
        elig1 = i_req1_valid & ~v1_q;
        gnt1  = (elig0 & elig1) ? ~last_q : elig1;
        rdy0  = idle & elig0 & ~gnt1;
        rdy1  = idle & elig1 & gnt1;
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        last_d   = last_q;
        arg0_d   = arg0_q;
        arg1_d   = arg1_q;
        oper_d   = oper_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        res0_d   = res0_q;
        res1_d   = res1_q;
        flg0_d   = flg0_q;
        flg1_d   = flg1_q;
        err_d    = err_q;

        if (v0_q && i_rsp0_ready) v0_d = 1'b0;
        if (v1_q && i_rsp1_ready) v1_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rdy0 || rdy1) begin
                    state_d  = EXEC;
                    cur_id_d = rdy1;
                    last_d   = rdy1;
                    arg0_d   = rdy1 ? i_req1_arg0 : i_req0_arg0;
                    arg1_d   = rdy1 ? i_req1_arg1 : i_req0_arg1;
                    oper_d   = rdy1 ? i_req1_oper : i_req0_oper;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                state_d = IDLE;
                if (cur_id_q) begin
                    v1_d   = 1'b1;
                    res1_d = i_alu_result;
                    flg1_d = i_alu_flag;
                end else begin
                    v0_d   = 1'b1;
                    res0_d = i_alu_result;
                    flg0_d = i_alu_flag;
                end
                if (i_alu_flag[0] && err_q != 8'hFF) err_d = err_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cur_id_q <= 1'b0;
            last_q   <= 1'b1;
            arg0_q   <= '0;
            arg1_q   <= '0;
            oper_q   <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            res0_q   <= '0;
            res1_q   <= '0;
            flg0_q   <= '0;
            flg1_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            last_q   <= last_d;
            arg0_q   <= arg0_d;
            arg1_q   <= arg1_d;
            oper_q   <= oper_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            flg0_q   <= flg0_d;
            flg1_q   <= flg1_d;
            err_q    <= err_d;
        end
    end

    assign o_req0_ready  = rdy0;
    assign o_req1_ready  = rdy1;
    assign o_rsp0_valid  = v0_q;
    assign o_rsp1_valid  = v1_q;
    assign o_rsp0_result = res0_q;
    assign o_rsp1_result = res1_q;
    assign o_rsp0_flag   = flg0_q;
    assign o_rsp1_flag   = flg1_q;
    assign o_alu_arg0    = arg0_q;
    assign o_alu_arg1    = arg1_q;
    assign o_alu_oper    = oper_q;
    assign o_busy        = ~idle;
    assign o_err_cnt     = err_q;

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares the single registered ALU (subtract / nand / starting-ones / one-hot decode) between two requesters. It accepts operations over a valid/ready handshake and drives the ALU operand and opcode inputs. One ALU clock later it captures the registered result and flags into a one-deep response slot owned by the issuing requester. It sits directly in front of the ALU at the datapath top level.

## Interface
- WIDTH, 4, operand/result width; must match the ALU WIDTH.
- i_clk  in  1  system clock, rising-edge; also clocks the ALU.
- i_rst  in  1  asynchronous, active-high reset. The ALU's active-low reset is driven from ~i_rst at top level.
- i_reqN_valid  in  1  requester N (N=0,1) has an operation pending.
- o_reqN_ready  out  1  arbiter accepts requester N this cycle.
- i_reqN_arg0, i_reqN_arg1  in  WIDTH  signed operands.
- i_reqN_oper  in  2  ALU opcode: 00 sub, 01 nand, 10 starting-ones, 11 decode.
- o_rspN_valid  out  1  response slot N full.
- i_rspN_ready  in  1  requester N consumes its response.
- o_rspN_result  out  WIDTH  captured ALU result.
- o_rspN_flag  out  4  captured ALU flags: [0] err, [1] neg, [2] pos, [3] overflow.
- o_alu_arg0, o_alu_arg1  out  WIDTH  registered operands to the ALU.
- o_alu_oper  out  2  registered opcode to the ALU.
- i_alu_result  in  WIDTH  ALU registered result.
- i_alu_flag  in  4  ALU registered flags.
- o_busy  out  1  FSM not in IDLE.
- o_err_cnt  out  8  saturating count of responses with flag[0]=1.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC on an accepted request.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- Eligibility: requester N is eligible when i_reqN_valid=1 and the registered slot N is empty (o_rspN_valid=0 at the start of the cycle).
  - A slot drained in a cycle makes its requester eligible only from the next cycle.
- Grant, evaluated only in IDLE:
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester not in last_grant is granted.
- o_reqN_ready = IDLE & eligible N & granted N. It is combinational and depends on valid. At most one ready is high per cycle.
- Accept edge (ready & valid):
  - latch arg0, arg1 and oper into o_alu_*;
  - latch the grant index into cur_id;
  - update last_grant to cur_id.
  - o_alu_* hold their value until the next accept.
- EXEC: the ALU registers its result at the EXEC→WB edge.
- WB: at the WB→IDLE edge, i_alu_result and i_alu_flag are written into slot cur_id, which sets o_rsp{cur_id}_valid.
  - The same edge increments o_err_cnt if i_alu_flag[0]=1. The counter saturates at 255.
- Response drain: o_rspN_valid & i_rspN_ready clears slot N at that edge.
  - Result and flag outputs keep their last value after clearing.
  - A drain and a capture never target the same slot in the same cycle, because a slot is granted only when empty.
- Requests seen outside IDLE are ignored (ready=0). Requesters must hold valid and data stable until accepted.
- Arithmetic: the arbiter passes data through untouched. It does no sign extension or recomputation of flags.

## Timing
- Reset (asynchronous, i_rst=1) forces:
  - state=IDLE, cur_id=0, last_grant=1 (so requester 0 wins the first tie);
  - o_alu_arg0/arg1/oper=0;
  - both slots empty, o_rspN_result=0, o_rspN_flag=0;
  - o_err_cnt=0, o_busy=0.
- Reset mid-operation discards the in-flight operation; no response is produced.
- Latency: accept at edge E0; o_rspN_valid is high in the cycle after E2 (3 cycles).
- Throughput: the earliest next accept is at E3, so one operation every 3 cycles.
- o_busy is high during the EXEC and WB cycles.
- The response is visible combinationally from the slot registers; the requester may drain it in the first valid cycle.

## Test plan
- Single op, WIDTH=4, ALU attached: req0 sends arg0=3, arg1=5, oper=00, rsp0_ready=1 → after 3 cycles rsp0_valid=1, result=4'hE, flag=4'b0010; req0_ready was high for exactly one cycle.
- Tie after reset: both valid in the same cycle → req0 granted first. Req1 is granted at the next IDLE (E3) and its response arrives 3 cycles later.
- Fairness: both valid continuously with responses always drained → grants alternate 0,1,0,1 over 8 operations; neither requester starves.
- Back-pressure: rsp0_ready=0 with req0 issuing twice → the second request gets no ready while slot 0 is full. Req1 is still served. Raising rsp0_ready lets req0 be accepted one cycle after the drain.
- Error counter: stub ALU returns flag=4'b0001 on 260 responses → o_err_cnt stays at 255.
- Reset in EXEC: assert i_rst for 1 cycle → all outputs at reset values, no rsp_valid appears, and the next request completes normally.
